falafel_lsu_arbiter: RTL
========================

Name: falafel_lsu_arbiter

Overview:
- Shares the single falafel LSU between N_REQ requesters, for example the malloc FSM and the free FSM.
- Grants one transaction at a time using round-robin priority.
- Honours LSU_OP_LOCK/LSU_OP_UNLOCK so that a requester can own the free list across several LSU accesses.
- Sits between the allocator control FSMs and the LSU; responses are routed back to the issuing requester.

Parameters:
- N_REQ, 2, number of requesters (2..8); requester 0 has the highest initial priority.
- DATA_W, 64, word width; a block payload is 2*DATA_W (size, next_ptr).
- LOCK_TIMEOUT, 1024, idle-while-locked cycle limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  N_REQ  per-requester request valid
- req_ready_o  out  N_REQ  one-hot accept pulse
- req_op_i  in  N_REQ*3  lsu_op_e encodings 0..5, requester i at bits [3i+2:3i]
- req_addr_i  in  N_REQ*DATA_W  byte address
- req_data_i  in  N_REQ*2*DATA_W  store word (low DATA_W) or store block
- rsp_valid_o  out  N_REQ  one-hot response pulse
- rsp_data_o  out  2*DATA_W  response data, broadcast to all requesters
- lsu_req_valid_o  out  1  LSU request valid
- lsu_req_ready_i  in  1  LSU accepts the request
- lsu_op_o  out  3  forwarded op
- lsu_addr_o  out  DATA_W  forwarded address
- lsu_data_o  out  2*DATA_W  forwarded data
- lsu_rsp_valid_i  in  1  LSU completion pulse
- lsu_rsp_data_i  in  2*DATA_W  LSU load data
- locked_o  out  1  arbiter is locked to one owner
- lock_owner_o  out  $clog2(N_REQ) (min 1)  current lock owner index
- lock_timeout_o  out  1  forced-release pulse; tied 0 without the feature

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer at 0, lock cleared.
  - Reset mid-transaction aborts it: lsu_req_valid_o is 0 in the cycle after reset is sampled.
  - A late lsu_rsp_valid_i arriving in IDLE is dropped.
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE, candidate set:
  - Unlocked: all requesters with req_valid_i set.
  - Locked: only lock_owner_o.
- IDLE, selection and accept:
  - Pick the first candidate at or after the round-robin pointer, wrapping modulo N_REQ.
  - Assert req_ready_o[g] combinationally in that same cycle.
  - Register g, op, addr and data; go to ISSUE.
  - No candidate: stay in IDLE.
- ISSUE:
  - Drive lsu_req_valid_o=1 with the registered payload, held stable until lsu_req_ready_i.
  - On lsu_req_ready_i, go to WAIT_RSP.
- WAIT_RSP, on lsu_rsp_valid_i:
  - Register rsp_data_o and pulse rsp_valid_o[g] for exactly one cycle, on the following cycle.
  - Return to IDLE.
  - rsp_data_o holds its value until the next response.
  - Stores and LOCK/UNLOCK also produce a response pulse; data is don't-care for these.
- Latency: minimum accept-to-rsp_valid is 3 cycles when lsu_req_ready_i and lsu_rsp_valid_i are both immediate (1 cycle each).
- Throughput: at most one outstanding transaction.
  - A new grant is possible in the IDLE cycle that coincides with the rsp_valid_o pulse.
  - Requesters must accept responses unconditionally; there is no response backpressure.
- Lock rules, applied at response time:
  - Completed LSU_OP_LOCK while unlocked: locked_o=1, lock_owner_o=g.
  - Completed LSU_OP_UNLOCK by the owner: locked_o=0.
  - LOCK by the owner while already locked: no change.
  - UNLOCK while unlocked: forwarded, no state change.
- Round robin:
  - After each response while unlocked, the pointer becomes (g+1) mod N_REQ.
  - While locked the pointer is frozen; on release it resumes at (owner+1) mod N_REQ.
- While locked, req_ready_o is never asserted for non-owners; their req_valid_i may stay high indefinitely.
- Ops are forwarded verbatim; the arbiter does not modify addresses.
- Opcodes 6 and 7 are forwarded verbatim and never affect lock state.

Optional Feature:
- Macro: FALAFEL_LSU_ARB_LOCK_TIMEOUT_EN.
- When defined:
  - A counter increments each IDLE cycle while locked and the owner's req_valid_i=0.
  - It clears on any owner grant.
  - On reaching LOCK_TIMEOUT, the lock is cleared and lock_timeout_o pulses for 1 cycle.
  - The round-robin pointer is set to (owner+1) mod N_REQ.
- When undefined: no counter, lock is held forever, lock_timeout_o is constant 0.

Test Plan:
- Single read: req0 LOAD_WORD addr 0x1000, LSU returns 0xDEAD immediately -> lsu_addr_o=0x1000, op=1, rsp_valid_o=01 three cycles after accept, rsp_data_o[63:0]=0xDEAD.
- Fairness: both requesters assert continuous LOAD_WORDs -> grant order 0,1,0,1; no requester waits more than one transaction.
- Lock: req1 LOCK, then 3 STORE_WORDs, then UNLOCK, with req0 valid throughout -> req0 gets no grant until 1 cycle after the UNLOCK response, then req0 is granted next.
- LSU stall: lsu_req_ready_i low for 5 cycles -> lsu_req_valid_o and payload stable for 6 cycles; no rsp_valid_o pulse and no new grant during the stall.
- Reset in WAIT_RSP: assert rst_i, then LSU response 2 cycles later -> no rsp_valid_o pulse, locked_o=0, the next request is granted to req0.
- With FALAFEL_LSU_ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=16: req0 locks, then goes idle -> lock_timeout_o pulses after 16 idle cycles, and pending req1 is granted the following cycle.

Source files
------------

// File: rtl/falafel_lsu_arbiter.sv
// falafel_lsu_arbiter: round-robin arbiter sharing one LSU between N_REQ requesters, with LOCK/UNLOCK ownership.
// Optional macro FALAFEL_LSU_ARB_LOCK_TIMEOUT_EN force-releases a lock whose owner stays idle for LOCK_TIMEOUT cycles.
module falafel_lsu_arbiter #(
   parameter int N_REQ        = 2,
   parameter int DATA_W       = 64,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [N_REQ-1:0]          req_valid_i,
   output logic [N_REQ-1:0]          req_ready_o,
   input  logic [N_REQ*3-1:0]        req_op_i,
   input  logic [N_REQ*DATA_W-1:0]   req_addr_i,
   input  logic [N_REQ*2*DATA_W-1:0] req_data_i,
   output logic [N_REQ-1:0]          rsp_valid_o,
   output logic [2*DATA_W-1:0]       rsp_data_o,
   output logic                      lsu_req_valid_o,
   input  logic                      lsu_req_ready_i,
   output logic [2:0]                lsu_op_o,
   output logic [DATA_W-1:0]         lsu_addr_o,
   output logic [2*DATA_W-1:0]       lsu_data_o,
   input  logic                      lsu_rsp_valid_i,
   input  logic [2*DATA_W-1:0]       lsu_rsp_data_i,
   output logic                      locked_o,
   output logic [$clog2(N_REQ)-1:0]  lock_owner_o,
   output logic                      lock_timeout_o
);
   localparam int IW = $clog2(N_REQ);
   localparam logic [2:0] OP_LOCK   = 3'd4;
   localparam logic [2:0] OP_UNLOCK = 3'd5;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

   state_e             state, state_nx;
   logic [IW-1:0]      gnt, rr, owner, pick;
   logic [IW:0]        sum;
   logic [N_REQ-1:0]   cand;
   logic [2*N_REQ-1:0] rot;
   logic               locked, found, accept, rsp_done, release_ok;

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
      return (x == IW'(N_REQ - 1)) ? '0 : x + IW'(1);
   endfunction

   always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_nx;

   // rot[i] is the candidate i positions after the pointer; the lowest set offset wins
   always_comb begin
      cand = locked ? (req_valid_i & (N_REQ'(1) << owner)) : req_valid_i;
      rot = {cand, cand} >> rr;
      found = 1'b0;
      sum = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (rot[i]) begin
            found = 1'b1;
            sum = {1'b0, rr} + (IW+1)'(i);
         end
      pick = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
      accept = state == IDLE && found && !rst_i;
      rsp_done = state == WAIT_RSP && lsu_rsp_valid_i;
      release_ok = locked && lsu_op_o == OP_UNLOCK && gnt == owner;
      state_nx = accept ? ISSUE : (state == ISSUE && lsu_req_ready_i) ? WAIT_RSP : rsp_done ? IDLE : state;
      req_ready_o = {N_REQ{accept}} & (N_REQ'(1) << pick);
   end

   assign lsu_req_valid_o = state == ISSUE;
   assign locked_o        = locked;
   assign lock_owner_o    = owner;

`ifdef FALAFEL_LSU_ARB_LOCK_TIMEOUT_EN
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);
   logic [CW-1:0] cnt;
   logic          tmo;
   assign lock_timeout_o = tmo;
`else
   // LOCK_TIMEOUT is always positive, so this is constant 0
   assign lock_timeout_o = LOCK_TIMEOUT < 0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt         <= '0;
         rr          <= '0;
         owner       <= '0;
         locked      <= 1'b0;
         lsu_op_o    <= '0;
         lsu_addr_o  <= '0;
         lsu_data_o  <= '0;
         rsp_valid_o <= '0;
         rsp_data_o  <= '0;
`ifdef FALAFEL_LSU_ARB_LOCK_TIMEOUT_EN
         cnt         <= '0;
         tmo         <= 1'b0;
`endif
      end else begin
         rsp_valid_o <= {N_REQ{rsp_done}} & (N_REQ'(1) << gnt);
         if (accept) begin
            gnt        <= pick;
            lsu_op_o   <= req_op_i[3*int'(pick) +: 3];
            lsu_addr_o <= req_addr_i[DATA_W*int'(pick) +: DATA_W];
            lsu_data_o <= req_data_i[2*DATA_W*int'(pick) +: 2*DATA_W];
         end
         if (rsp_done) begin
            rsp_data_o <= lsu_rsp_data_i;
            if (!locked && lsu_op_o == OP_LOCK) begin
               locked <= 1'b1;
               owner  <= gnt;
            end
            if (release_ok) locked <= 1'b0;
            if (!locked || release_ok) rr <= nxt(gnt);
         end
`ifdef FALAFEL_LSU_ARB_LOCK_TIMEOUT_EN
         tmo <= 1'b0;
         if (!locked || accept) cnt <= '0;
         else if (state == IDLE && !req_valid_i[owner]) begin
            if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
               locked <= 1'b0;
               tmo    <= 1'b1;
               rr     <= nxt(owner);
               cnt    <= '0;
            end else cnt <= cnt + CW'(1);
         end
`endif
      end
   end
endmodule
